// File: rtl/spi_awaiba_pkg.sv
// Shared frame layout and FSM encoding for the camera-control SPI link.
// This package is used by spi_awaiba, spi_awaiba_resp and their benches.
package spi_awaiba_pkg;

  localparam int FRM_W    = 16;
  localparam int W_BIT    = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // Counts sclk rises within a frame. It stops counting at 16.
  localparam int                CNT_W        = 5;
  localparam logic [CNT_W-1:0]  CNT_FULL     = 5'd16;
  localparam logic [CNT_W-1:0]  CNT_HDR      = 5'd8;
  localparam logic [CNT_W-1:0]  CNT_HDR_LAST = 5'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  function automatic logic addr_mapped(input logic [31:0] addr, input logic [31:0] depth);
    addr_mapped = (addr < depth);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin.
// It outputs the synchronised level plus single-cycle rise and fall strobes.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchroniser chain plus one extra flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{RST_VAL}};
      prev_r <= RST_VAL;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Edge strobes derived from the synchronised level.
  always_comb begin
    lvl  = sync_r[SYNC_STAGES-1];
    rise = sync_r[SYNC_STAGES-1] & ~prev_r;
    fall = ~sync_r[SYNC_STAGES-1] & prev_r;
  end

endmodule

// File: rtl/spi_awaiba_resp.sv
// SPI responder (sensor model) for the camera-control link. It receives 16-bit frames
// into two register banks and answers read frames on miso. All logic runs on clk only.
module spi_awaiba_resp
  import spi_awaiba_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int REG_DEPTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  input  logic              abn_cdp,
  output logic              miso,
  output logic              o_wr_vld,
  output logic              o_wr_bank,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_frm_err,
  input  logic              i_rd_bank,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int          IDX_W   = $clog2(REG_DEPTH);
  localparam logic [31:0] DEPTH_L = 32'(REG_DEPTH);

  logic sclk_rise_s, sclk_fall_s, sclk_lvl_unused_s;
  logic mosi_lvl_s, mosi_rise_unused_s, mosi_fall_unused_s;
  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic abn_lvl_s, abn_rise_unused_s, abn_fall_unused_s;

  spi_state_e             state_r, state_s;
  logic [FRM_W-1:0]       shift_r, shift_nxt_s;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic                   bank_r, ovr_r;
  logic [DATA_W-1:0]      tx_r, spi_rd_s;
  logic [ADDR_W-1:0]      hdr_addr_s, frm_addr_s;
  logic                   hdr_wr_s, hdr_map_s, frm_wr_s, frm_map_s, reg_we_s;
  logic                   start_s, shift_s, fall_s, ovr_s, close_s, commit_s, abort_s;
  logic [DATA_W-1:0]      regs_r [2][REG_DEPTH];

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .lvl(sclk_lvl_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .lvl(mosi_lvl_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
  );
  // cs_n resets high, so a pin that is already idle does not produce a false edge.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n),
    .lvl(cs_lvl_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_abn (
    .clk(clk), .rst(rst), .din(abn_cdp),
    .lvl(abn_lvl_s), .rise(abn_rise_unused_s), .fall(abn_fall_unused_s)
  );

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and per-cycle frame event decode.
  always_comb begin
    state_s  = state_r;
    start_s  = 1'b0;
    shift_s  = 1'b0;
    fall_s   = 1'b0;
    ovr_s    = 1'b0;
    close_s  = 1'b0;
    commit_s = 1'b0;
    abort_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) begin
          state_s = SHIFT;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cs_rise_s) begin
          state_s = IDLE;
          close_s = 1'b1;
          // An overrun frame was already flagged on its 17th rise, so it ends silently.
          if (ovr_r) begin
            commit_s = 1'b0;
          end else if (bit_cnt_r == CNT_FULL) begin
            commit_s = 1'b1;
          end else begin
            abort_s = 1'b1;
          end
        end else if (cs_lvl_s) begin
          state_s = SHIFT;
        end else if (sclk_rise_s) begin
          if (bit_cnt_r == CNT_FULL) begin
            ovr_s = ~ovr_r;
          end else begin
            shift_s = 1'b1;
          end
        end else if (sclk_fall_s) begin
          fall_s = 1'b1;
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Header/frame field extraction and the bank lookup for the SPI read path.
  always_comb begin
    shift_nxt_s = {shift_r[FRM_W-2:0], mosi_lvl_s};
    hdr_wr_s    = shift_nxt_s[W_BIT-ADDR_LSB];
    hdr_addr_s  = shift_nxt_s[ADDR_MSB-ADDR_LSB:0];
    hdr_map_s   = addr_mapped(32'(hdr_addr_s), DEPTH_L);
    frm_wr_s    = shift_r[W_BIT];
    frm_addr_s  = shift_r[ADDR_MSB:ADDR_LSB];
    frm_map_s   = addr_mapped(32'(frm_addr_s), DEPTH_L);
    reg_we_s    = commit_s & frm_wr_s & frm_map_s;
    if (hdr_map_s) begin
      spi_rd_s = regs_r[bank_r][hdr_addr_s[IDX_W-1:0]];
    end else begin
      spi_rd_s = {DATA_W{1'b0}};
    end
  end

  // Shift/transmit datapath and the registered result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r   <= {FRM_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      bank_r    <= 1'b0;
      ovr_r     <= 1'b0;
      tx_r      <= {DATA_W{1'b0}};
      miso      <= 1'b0;
      o_wr_vld  <= 1'b0;
      o_wr_bank <= 1'b0;
      o_wr_addr <= {ADDR_W{1'b0}};
      o_wr_data <= {DATA_W{1'b0}};
      o_frm_err <= 1'b0;
    end else begin
      o_wr_vld  <= 1'b0;
      o_frm_err <= 1'b0;
      if (start_s) begin
        bank_r    <= abn_lvl_s;
        shift_r   <= {FRM_W{1'b0}};
        bit_cnt_r <= {CNT_W{1'b0}};
        ovr_r     <= 1'b0;
        tx_r      <= {DATA_W{1'b0}};
        miso      <= 1'b0;
      end
      if (shift_s) begin
        shift_r   <= shift_nxt_s;
        bit_cnt_r <= bit_cnt_r + 5'd1;
        // The header is complete on the 8th rise. Only read frames load reply data.
        if (bit_cnt_r == CNT_HDR_LAST) begin
          tx_r <= hdr_wr_s ? {DATA_W{1'b0}} : spi_rd_s;
        end
      end
      if (fall_s) begin
        if ((bit_cnt_r >= CNT_HDR) && (bit_cnt_r < CNT_FULL)) begin
          miso <= tx_r[DATA_W-1];
          tx_r <= {tx_r[DATA_W-2:0], 1'b0};
        end else begin
          miso <= 1'b0;
        end
      end
      if (ovr_s) begin
        ovr_r     <= 1'b1;
        o_frm_err <= 1'b1;
      end
      if (close_s) begin
        miso <= 1'b0;
        tx_r <= {DATA_W{1'b0}};
      end
      if (abort_s) begin
        o_frm_err <= 1'b1;
      end
      // An unmapped write still reports its commit, but it does not store the data.
      if (commit_s && frm_wr_s) begin
        o_wr_vld  <= 1'b1;
        o_wr_bank <= bank_r;
        o_wr_addr <= frm_addr_s;
        o_wr_data <= shift_r[DATA_MSB:DATA_LSB];
      end
    end
  end

  // Register banks A/B. They are written only by a committed, mapped write frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < REG_DEPTH; i++) begin
          regs_r[b][i] <= {DATA_W{1'b0}};
        end
      end
    end else if (reg_we_s) begin
      regs_r[bank_r][frm_addr_s[IDX_W-1:0]] <= shift_r[DATA_MSB:DATA_LSB];
    end
  end

  // Local read port, one cycle of latency. A same-cycle commit returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rd_data <= {DATA_W{1'b0}};
    end else if (addr_mapped(32'(i_rd_addr), DEPTH_L)) begin
      o_rd_data <= regs_r[i_rd_bank][i_rd_addr[IDX_W-1:0]];
    end else begin
      o_rd_data <= {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_spi_awaiba_resp.sv
// Directed bench for spi_awaiba_resp. The bench acts as the SPI master.
// A bank model and queues of expected events are checked on every clk.
module tb_spi_awaiba_resp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       abn_cdp = 1'b0;
  logic       i_rd_bank = 1'b0;
  logic [6:0] i_rd_addr = 7'd0;
  logic       miso, o_wr_vld, o_wr_bank, o_frm_err;
  logic [6:0] o_wr_addr;
  logic [7:0] o_wr_data, o_rd_data;

  spi_awaiba_resp dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .abn_cdp(abn_cdp),
    .miso(miso), .o_wr_vld(o_wr_vld), .o_wr_bank(o_wr_bank), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_frm_err(o_frm_err), .i_rd_bank(i_rd_bank),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       bank;
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  int         total = 0;
  int         bad = 0;
  int         exp_err = 0;
  wr_t        wq[$];
  logic [7:0] model [2][128];
  logic [7:0] last_data = 8'h00;
  logic       idle_chk = 1'b0;
  logic [7:0] rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] model_rd(input logic b, input logic [6:0] a);
    return (a < 7'd32) ? model[b][a] : 8'h00;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 128; i++)
        model[b][i] = 8'h00;
  endtask

  // Drives one frame of nbits sclk pulses and returns the miso byte sampled on rises 9..16.
  task automatic frame(input logic bank, input logic [15:0] w, input int nbits,
                       output logic [7:0] r);
    wr_t e;
    r = 8'h00;
    if (nbits == 16 && w[15]) begin
      e = {bank, w[14:8], w[7:0]};
      wq.push_back(e);
    end
    if (nbits != 16) exp_err++;
    idle_chk = 1'b0;
    abn_cdp = bank;
    cs_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) mosi = w[15-i];
      else mosi = 1'b0;
      wait_clk(5);
      if (i >= 8 && i < 16) r[15-i] = miso;
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(8);
    if (nbits == 16 && w[15] && w[14:8] < 7'd32) model[bank][w[14:8]] = w[7:0];
    idle_chk = 1'b1;
  endtask

  task automatic spi_write(input logic bank, input logic [6:0] a, input logic [7:0] d);
    logic [7:0] r;
    frame(bank, {1'b1, a, d}, 16, r);
    check("spi_wr_miso_zero", {24'd0, r}, 32'd0);
  endtask

  task automatic spi_read(input logic bank, input logic [6:0] a, output logic [7:0] r);
    logic [7:0] exp;
    exp = model_rd(bank, a);
    frame(bank, {1'b0, a, 8'h00}, 16, r);
    check("spi_rd_model", {24'd0, r}, {24'd0, exp});
  endtask

  task automatic local_rd(input logic b, input logic [6:0] a, output logic [7:0] d);
    i_rd_bank = b;
    i_rd_addr = a;
    wait_clk(2);
    d = o_rd_data;
    check("local_rd_model", {24'd0, d}, {24'd0, model_rd(b, a)});
  endtask

  // Compares the commit pulses, error pulses, data hold and idle miso against the model.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (o_wr_vld) begin
        check("wr_vld_expected", {31'd0, wq.size() != 0}, 32'd1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          check("wr_bank", {31'd0, o_wr_bank}, {31'd0, e.bank});
          check("wr_addr", {25'd0, o_wr_addr}, {25'd0, e.addr});
          check("wr_data", {24'd0, o_wr_data}, {24'd0, e.data});
          last_data = e.data;
        end
      end else begin
        check("wr_data_hold", {24'd0, o_wr_data}, {24'd0, last_data});
      end
      if (o_frm_err) begin
        check("frm_err_expected", {31'd0, exp_err > 0}, 32'd1);
        if (exp_err > 0) exp_err--;
      end
      if (idle_chk) check("miso_idle", {31'd0, miso}, 32'd0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    model_clear();
    wait_clk(4);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_wr_vld", {31'd0, o_wr_vld}, 32'd0);
    check("rst_frm_err", {31'd0, o_frm_err}, 32'd0);
    check("rst_wr_data", {24'd0, o_wr_data}, 32'd0);
    check("rst_rd_data", {24'd0, o_rd_data}, 32'd0);
    rst = 1'b0;
    wait_clk(4);
    idle_chk = 1'b1;

    // Write to bank A, then read it back through the local port and over SPI.
    spi_write(1'b0, 7'h0A, 8'h5C);
    local_rd(1'b0, 7'h0A, d);
    check("lit_local_A0A", {24'd0, d}, 32'h5C);
    spi_read(1'b0, 7'h0A, rx);
    check("lit_spi_A0A", {24'd0, rx}, 32'h5C);

    // Bank isolation.
    spi_write(1'b1, 7'h0A, 8'h33);
    local_rd(1'b0, 7'h0A, d);
    check("lit_iso_A0A", {24'd0, d}, 32'h5C);
    local_rd(1'b1, 7'h0A, d);
    check("lit_iso_B0A", {24'd0, d}, 32'h33);
    spi_read(1'b1, 7'h0A, rx);
    check("lit_spi_B0A", {24'd0, rx}, 32'h33);

    // An aborted frame of 9 bits stores nothing. The next full frame must still work.
    frame(1'b0, 16'h8AFF, 9, rx);
    local_rd(1'b0, 7'h0A, d);
    check("lit_abort_keep", {24'd0, d}, 32'h5C);
    spi_write(1'b0, 7'h0B, 8'h77);
    spi_read(1'b0, 7'h0B, rx);
    check("lit_after_abort", {24'd0, rx}, 32'h77);

    // Overrun frame, then a write and a read to an unmapped address.
    frame(1'b0, 16'h8A00, 17, rx);
    local_rd(1'b0, 7'h0A, d);
    check("lit_ovr_keep", {24'd0, d}, 32'h5C);
    spi_write(1'b0, 7'h3F, 8'h11);
    spi_read(1'b0, 7'h3F, rx);
    check("lit_unmapped_spi", {24'd0, rx}, 32'h00);
    local_rd(1'b0, 7'h3F, d);
    check("lit_unmapped_local", {24'd0, d}, 32'h00);
    local_rd(1'b0, 7'h1F, d);

    // Reset in the middle of a frame. Reset clears the banks.
    idle_chk = 1'b0;
    abn_cdp = 1'b0;
    cs_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 5; i++) begin
      mosi = (i % 2 == 0);
      wait_clk(5);
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
    rst = 1'b1;
    cs_n = 1'b1;
    last_data = 8'h00;
    model_clear();
    wait_clk(4);
    check("midrst_miso", {31'd0, miso}, 32'd0);
    rst = 1'b0;
    wait_clk(6);
    idle_chk = 1'b1;
    local_rd(1'b0, 7'h0A, d);
    check("lit_rst_cleared", {24'd0, d}, 32'h00);
    spi_write(1'b0, 7'h01, 8'h01);
    local_rd(1'b0, 7'h01, d);
    check("lit_post_rst_wr", {24'd0, d}, 32'h01);

    wait_clk(10);
    check("wr_queue_drained", wq.size(), 32'd0);
    check("frm_err_drained", exp_err, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
